// File: rtl/count_pkg.sv
// Shared width and value type for the loadable up/down counter.
package count_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage : count_pkg

// File: rtl/counter_next.sv
// Combinational next-count: load takes din, otherwise step up or down modulo 2**WIDTH.
module counter_next #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_i,
  input  logic             up_down_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  // Wrap-around falls out of the fixed-width add/subtract; no carry is kept.
  always_comb begin
    next_o = count_i;
    if (load_i) begin
      next_o = din_i;
    end else if (up_down_i) begin
      next_o = count_i + One;
    end else begin
      next_o = count_i - One;
    end
  end

endmodule : counter_next

// File: rtl/updown_load_counter.sv
// Loadable up/down counter; rst_n is active-high and synchronous despite its name.
module updown_load_counter
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_counter_next (
    .count_i  (count_q),
    .load_i   (load),
    .up_down_i(up_down),
    .din_i    (din),
    .next_o   (count_d)
  );

  // Reset overrides the next-state path, so unknown inputs during reset never reach count_q.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : updown_load_counter

// File: tb/tb_updown_load_counter.sv
// Directed table-driven bench for updown_load_counter plus reset corner sequences.
module tb_updown_load_counter;
  import count_pkg::*;

  logic clk;
  logic rst_n;
  logic load;
  logic up_down;
  cnt_t din;
  cnt_t count;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic  rst;
    logic  ld;
    logic  ud;
    cnt_t  d;
    cnt_t  exp;
    string name;
  } vec_t;

  vec_t vecs[$];

  updown_load_counter #(
    .WIDTH(CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .up_down(up_down),
    .din    (din),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input cnt_t exp, input string name);
    cmp_cnt++;
    if (count !== exp) begin
      err_cnt++;
      $display("FAIL %s: count=%h expected=%h", name, count, exp);
    end
  endtask

  // Drive inputs, take one rising edge, check 1 time unit later.
  task automatic step(input logic r, input logic l, input logic u, input cnt_t d,
                      input cnt_t exp, input string name);
    rst_n   = r;
    load    = l;
    up_down = u;
    din     = d;
    @(posedge clk);
    #1;
    check(exp, name);
  endtask

  function automatic vec_t mk(input logic r, input logic l, input logic u, input cnt_t d,
                              input cnt_t exp, input string name);
    vec_t v;
    v.rst  = r;
    v.ld   = l;
    v.ud   = u;
    v.d    = d;
    v.exp  = exp;
    v.name = name;
    return v;
  endfunction

  initial begin
    rst_n   = 1'b1;
    load    = 1'b0;
    up_down = 1'b0;
    din     = '0;

    // Reset with random load/din
    vecs.push_back(mk(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                      cnt_t'($urandom_range(15)), 4'h0, "reset_0"));
    vecs.push_back(mk(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                      cnt_t'($urandom_range(15)), 4'h0, "reset_1"));
    // Load then up
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h5, 4'h5, "load_5"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0, 4'h6, "up_6"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'hC, 4'h7, "up_7"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h3, 4'h8, "up_8"));
    // Up wrap
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hE, 4'hE, "load_e"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0, 4'hF, "upwrap_f"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "upwrap_0"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0, 4'h1, "upwrap_1"));
    // Down wrap
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h1, 4'h1, "load_1"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h7, 4'h0, "dnwrap_0"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h7, 4'hF, "dnwrap_f"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h7, 4'hE, "dnwrap_e"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 4'hD, "down_d"));
    // Priority: load beats up_down, reset beats load
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h9, 4'h9, "prio_load_up"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hA, 4'hA, "prio_load_dn"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'h3, 4'h0, "prio_rst_load"));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].ud, vecs[i].d, vecs[i].exp, vecs[i].name);
    end

    // Reset mid-run: count up from 0 to 6, reset one cycle, resume from 0
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'h0, cnt_t'(i), "midrun_up");
    end
    step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, "midrun_rst");
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h1, "midrun_resume_1");
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h2, "midrun_resume_2");

    // Unknown inputs while reset is held must leave count at 0
    step(1'b1, 1'bx, 1'bx, 4'bxxxx, 4'h0, "x_rst_0");
    step(1'b1, 1'bx, 1'bx, 4'bxxxx, 4'h0, "x_rst_1");
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, "x_release_down");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_updown_load_counter
